// File: rtl/quad_decoder_v3_if.sv
// Bundles the encoder pins, control strobes and decoded results of quad_decoder_v3.
// The master modport drives the pins and controls; the slave modport is the decoder side.
interface quad_decoder_v3_if #(
  parameter int CNT_W = 32,
  parameter int VEL_W = 16
);
  logic             quad_a;
  logic             quad_b;
  logic             quad_i;
  logic [1:0]       mode;
  logic             idx_clr_en;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             err_clr;
  logic [CNT_W-1:0] count;
  logic             dir;
  logic             err;
  logic             idx_seen;
  logic [CNT_W-1:0] idx_pos;
  logic [VEL_W-1:0] vel;
  logic             vel_valid;

  modport master (
    output quad_a, quad_b, quad_i, mode, idx_clr_en, load, load_val, err_clr,
    input  count, dir, err, idx_seen, idx_pos, vel, vel_valid
  );

  modport slave (
    input  quad_a, quad_b, quad_i, mode, idx_clr_en, load, load_val, err_clr,
    output count, dir, err, idx_seen, idx_pos, vel, vel_valid
  );
endinterface

// File: rtl/quad_decoder_v3.sv
// Quadrature encoder decoder: synchronise, glitch-filter, x4/x2/x1 decode, index capture.
// Define QUAD_DECODER_V3_VEL_EN to build the windowed velocity measurement.
module quad_decoder_v3 #(
  parameter int CNT_W      = 32,
  parameter int FILT_LEN   = 4,
  parameter int VEL_W      = 16,
  parameter int VEL_PERIOD = 1000
) (
  input  logic              clk,
  input  logic              rst,
  quad_decoder_v3_if.slave  bus
);

  localparam logic [7:0]       FiltLast = 8'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  // Channel order in the 3-bit vectors: [0]=A, [1]=B, [2]=index.
  logic [2:0]       sync1_q, sync2_q, filt_q, prev_q;
  logic [7:0]       fcnt_q [3];
  logic             primed_q;
  logic [CNT_W-1:0] count_q, count_d, idx_pos_q;
  logic             dir_q, err_q, idx_seen_q;

  logic a_chg, b_chg, err_evt, step, up, idx_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {bus.quad_i, bus.quad_b, bus.quad_a};
      sync2_q <= sync1_q;
    end
  end

  // A channel only follows its synchroniser after FILT_LEN unbroken cycles of disagreement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= '0;
      for (int c = 0; c < 3; c++) fcnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (sync2_q[c] == filt_q[c]) begin
          fcnt_q[c] <= '0;
        end else if (fcnt_q[c] == FiltLast) begin
          filt_q[c] <= sync2_q[c];
          fcnt_q[c] <= '0;
        end else begin
          fcnt_q[c] <= fcnt_q[c] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    a_chg    = filt_q[0] ^ prev_q[0];
    b_chg    = filt_q[1] ^ prev_q[1];
    err_evt  = primed_q & a_chg & b_chg;
    idx_rise = primed_q & filt_q[2] & ~prev_q[2];
    step     = 1'b0;
    up       = 1'b0;
    if (primed_q && !(a_chg && b_chg)) begin
      case (bus.mode)
        2'd1: begin
          if (a_chg) begin
            step = 1'b1;
            up   = filt_q[0] ^ filt_q[1];
          end
        end
        2'd2: begin
          if (a_chg && filt_q[0]) begin
            step = 1'b1;
            up   = ~filt_q[1];
          end
        end
        default: begin
          if (a_chg) begin
            step = 1'b1;
            up   = filt_q[0] ^ filt_q[1];
          end else if (b_chg) begin
            step = 1'b1;
            up   = ~(filt_q[0] ^ filt_q[1]);
          end
        end
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (bus.load) begin
      count_d = bus.load_val;
    end else if (idx_rise && bus.idx_clr_en) begin
      count_d = '0;
    end else if (step) begin
      count_d = up ? count_q + CntOne : count_q - CntOne;
    end
  end

  // prev_q tracks the filtered pins every cycle; primed_q masks the first cycle after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      primed_q   <= 1'b0;
      count_q    <= '0;
      idx_pos_q  <= '0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      idx_seen_q <= 1'b0;
    end else begin
      prev_q   <= filt_q;
      primed_q <= 1'b1;
      count_q  <= count_d;
      if (step) dir_q <= up;
      if (err_evt) begin
        err_q <= 1'b1;
      end else if (bus.err_clr) begin
        err_q <= 1'b0;
      end
      if (idx_rise) begin
        idx_seen_q <= 1'b1;
        idx_pos_q  <= count_q;
      end
    end
  end

  assign bus.count    = count_q;
  assign bus.dir      = dir_q;
  assign bus.err      = err_q;
  assign bus.idx_seen = idx_seen_q;
  assign bus.idx_pos  = idx_pos_q;

`ifdef QUAD_DECODER_V3_VEL_EN
  localparam int                      WinW    = (VEL_PERIOD > 1) ? $clog2(VEL_PERIOD) : 1;
  localparam logic [WinW-1:0]         WinLast = WinW'(VEL_PERIOD - 1);
  localparam logic signed [VEL_W-1:0] VelOne  = VEL_W'(1);
  localparam logic signed [VEL_W-1:0] VelMax  = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W-1:0] VelMin  = -VelMax;

  logic [WinW-1:0]         win_q;
  logic signed [VEL_W-1:0] acc_q, acc_d, vel_q;
  logic                    vel_valid_q;

  // Velocity only sees decoded steps; loads and index clears do not disturb it.
  always_comb begin
    acc_d = acc_q;
    if (step && up && acc_q != VelMax) begin
      acc_d = acc_q + VelOne;
    end else if (step && !up && acc_q != VelMin) begin
      acc_d = acc_q - VelOne;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q       <= '0;
      acc_q       <= '0;
      vel_q       <= '0;
      vel_valid_q <= 1'b0;
    end else if (win_q == WinLast) begin
      win_q       <= '0;
      acc_q       <= '0;
      vel_q       <= acc_d;
      vel_valid_q <= 1'b1;
    end else begin
      win_q       <= win_q + WinW'(1);
      acc_q       <= acc_d;
      vel_valid_q <= 1'b0;
    end
  end

  assign bus.vel       = vel_q;
  assign bus.vel_valid = vel_valid_q;
`else
  assign bus.vel       = '0;
  assign bus.vel_valid = 1'b0;
`endif

endmodule
